// File: rtl/ptos_lane_scheduler_if.sv
// Lane-side and serializer-side signal bundle for ptos_lane_scheduler.
// The master modport is the scheduler; the slave modport is the lane/serializer environment.
interface ptos_lane_scheduler_if #(
    parameter int NUM_LANES = 4
);
    localparam int LW = $clog2(NUM_LANES);

    logic [8*NUM_LANES-1:0] lane_data;
    logic [NUM_LANES-1:0]   lane_valid;
    logic [NUM_LANES-1:0]   lane_pop;
    logic [7:0]             data_out;
    logic                   valid_out;
    logic [LW-1:0]          lane_sel;
    logic                   frame_start;
    logic                   sync_done;
    logic [15:0]            frames_sent;

    modport master (
        input  lane_data, lane_valid,
        output lane_pop, data_out, valid_out, lane_sel, frame_start, sync_done, frames_sent
    );

    modport slave (
        output lane_data, lane_valid,
        input  lane_pop, data_out, valid_out, lane_sel, frame_start, sync_done, frames_sent
    );
endinterface

// File: rtl/ptos_lane_scheduler.sv
// Frame-aligned round-robin scheduler feeding one byte per 8-cycle frame to the shared serializer.
// state   | meaning
// ST_SYNC | after reset: comma frames only, counting boundaries up to SYNC_FRAMES
// ST_RUN  | round-robin arbitration at every frame boundary
module ptos_lane_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int SYNC_FRAMES = 4
) (
    input  logic i_clk_32f,
    input  logic i_reset,
    input  logic i_enable,
    ptos_lane_scheduler_if.master bus
);
    localparam int LW = $clog2(NUM_LANES);

    typedef enum logic {ST_SYNC, ST_RUN} state_t;

    state_t                r_state;
    logic [2:0]            r_phase;
    logic [3:0]            r_comma_cnt;
    logic [LW-1:0]         r_rr_ptr;
    logic [7:0]            r_data_out;
    logic                  r_valid_out;
    logic [LW-1:0]         r_lane_sel;
    logic [NUM_LANES-1:0]  r_lane_pop;
    logic                  r_frame_start;
    logic                  r_sync_done;
    logic [15:0]           r_frames_sent;

    logic                  w_found;
    logic [LW-1:0]         w_win;
    logic [LW-1:0]         w_idx;
    logic                  w_arb_en;
    logic [7:0]            w_byte;

    // Search starts one past the last winner; the LW-bit add wraps for power-of-two lane counts.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_idx   = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            w_idx = r_rr_ptr + LW'(i);
            if (!w_found && bus.lane_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_arb_en = i_enable && ((r_state == ST_RUN) || (r_comma_cnt == 4'(SYNC_FRAMES)));
    assign w_byte   = bus.lane_data[{w_win, 3'b000} +: 8];

    always_ff @(posedge i_clk_32f) begin
        if (!i_reset) begin
            r_state       <= ST_SYNC;
            r_phase       <= 3'd0;
            r_comma_cnt   <= 4'd0;
            r_rr_ptr      <= LW'(NUM_LANES - 1);
            r_data_out    <= 8'hBC;
            r_valid_out   <= 1'b0;
            r_lane_sel    <= '0;
            r_lane_pop    <= '0;
            r_frame_start <= 1'b0;
            r_sync_done   <= 1'b0;
            r_frames_sent <= 16'd0;
        end else begin
            r_phase       <= r_phase + 3'd1;
            r_lane_pop    <= '0;
            r_frame_start <= 1'b0;
            if (r_phase == 3'd7) begin
                r_frame_start <= 1'b1;
                // The boundary that finds the comma count complete is also the first grant slot.
                if (r_state == ST_SYNC) begin
                    if (r_comma_cnt == 4'(SYNC_FRAMES)) begin
                        r_state     <= ST_RUN;
                        r_sync_done <= 1'b1;
                    end else begin
                        r_comma_cnt <= r_comma_cnt + 4'd1;
                    end
                end
                if (w_arb_en && w_found) begin
                    r_data_out    <= w_byte;
                    r_valid_out   <= 1'b1;
                    r_lane_sel    <= w_win;
                    r_lane_pop    <= NUM_LANES'(1) << w_win;
                    r_rr_ptr      <= w_win;
                    r_frames_sent <= r_frames_sent + 16'd1;
                end else begin
                    r_data_out  <= 8'hBC;
                    r_valid_out <= 1'b0;
                end
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.valid_out   = r_valid_out;
    assign bus.lane_sel    = r_lane_sel;
    assign bus.lane_pop    = r_lane_pop;
    assign bus.frame_start = r_frame_start;
    assign bus.sync_done   = r_sync_done;
    assign bus.frames_sent = r_frames_sent;
endmodule
